// File: rtl/hazard_if.sv
// Pipeline-side hazard signals: source/destination info from ID and EX, branch
// resolution, data-memory handshake, and the stage enables/flushes/redirect driven back.
interface hazard_if;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        ifid_rs1_used;
  logic        ifid_rs2_used;
  logic        idex_mem_read;
  logic [4:0]  idex_rd;
  logic        ex_branch_valid;
  logic        ex_prediction;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_pc4;
  logic        mem_access;
  logic        dmem_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used, idex_mem_read, idex_rd,
           ex_branch_valid, ex_prediction, ex_taken, ex_target, ex_pc4,
           mem_access, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used, idex_mem_read, idex_rd,
           ex_branch_valid, ex_prediction, ex_taken, ex_target, ex_pc4,
           mem_access, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard controller for the five-stage core: load-use stall, branch mispredict redirect,
// data-memory freeze, saturating perf counters and a sticky memory-timeout flag.
//
// state    | meaning
// RUN      | pipeline advancing; no data-memory access outstanding
// MEM_WAIT | data-memory access outstanding; pipe frozen until dmem_ready
module hazard_control_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  hazard_if.slave          hz,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             mem_timeout
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              freeze;
  logic              mispredict;
  logic              load_use;
  logic              rs1_hit;
  logic              rs2_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (hz.mem_access && !hz.dmem_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (hz.dmem_ready) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // The completing cycle (dmem_ready=1) is not frozen: MEM/WB captures the data then.
  // During the rst cycle the outputs follow RUN rules even if state is still MEM_WAIT.
  always_comb begin
    waiting    = (state == MEM_WAIT) && !rst;
    freeze     = !hz.dmem_ready && (waiting || hz.mem_access);
    rs1_hit    = hz.ifid_rs1_used && (hz.ifid_rs1 == hz.idex_rd);
    rs2_hit    = hz.ifid_rs2_used && (hz.ifid_rs2 == hz.idex_rd);
    mispredict = !freeze && hz.ex_branch_valid && (hz.ex_taken != hz.ex_prediction);
    load_use   = !freeze && !mispredict && hz.idex_mem_read && (hz.idex_rd != 5'd0)
                 && (rs1_hit || rs2_hit);
  end

  always_comb begin
    hz.pc_en          = 1'b1;
    hz.ifid_en        = 1'b1;
    hz.idex_en        = 1'b1;
    hz.exmem_en       = 1'b1;
    hz.memwb_en       = 1'b1;
    hz.ifid_flush     = 1'b0;
    hz.idex_flush     = 1'b0;
    hz.redirect_valid = 1'b0;
    hz.redirect_pc    = 32'd0;
    if (freeze) begin
      hz.pc_en    = 1'b0;
      hz.ifid_en  = 1'b0;
      hz.idex_en  = 1'b0;
      hz.exmem_en = 1'b0;
      hz.memwb_en = 1'b0;
    end else if (mispredict) begin
      hz.ifid_flush     = 1'b1;
      hz.idex_flush     = 1'b1;
      hz.redirect_valid = 1'b1;
      hz.redirect_pc    = hz.ex_taken ? hz.ex_target : hz.ex_pc4;
    end else if (load_use) begin
      hz.pc_en      = 1'b0;
      hz.ifid_en    = 1'b0;
      hz.idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      stall_count      <= '0;
      mispredict_count <= '0;
      wait_cnt         <= '0;
      mem_timeout      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!hz.pc_en && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + 1'b1;
      if ((state == RUN) && (state_nxt == MEM_WAIT)) begin
        wait_cnt <= '0;
      end else if (state == MEM_WAIT) begin
        if (wait_cnt != WAIT_W'(MEM_TIMEOUT))
          wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))
          mem_timeout <= 1'b1;
      end
    end
  end

endmodule
